// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Build option: define SRAM_ARB_RR_EN to get round-robin tie breaking
// (see sram_arb_pick); by default the data port wins ties.
package sram_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    // Which requester owns (or last owned) the SRAM
    typedef enum logic {
        ARB_GNT_IF  = 1'b0,
        ARB_GNT_MEM = 1'b1
    } arb_gnt_e;

    // Access counter width; covers ACC_CYCLES up to 15
    localparam int ACC_CNT_W = 4;

    // Fetches always read a full word
    localparam logic [3:0] SEL_ALL = 4'hF;

    // Counter load value for an access of acc_cycles cycles
    function automatic logic [ACC_CNT_W-1:0] acc_load(input int acc_cycles);
        return ACC_CNT_W'(acc_cycles - 1);
    endfunction

    // The requester that is not p
    function automatic arb_gnt_e other_port(input arb_gnt_e p);
        return (p == ARB_GNT_IF) ? ARB_GNT_MEM : ARB_GNT_IF;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of fetch-port, data-port, stall and SRAM-side signals around the
// arbiter. slave = arbiter side, master = requesters/SRAM/bench side.
interface sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    // Instruction-fetch port
    logic              if_ce_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ack_o;

    // Data (mem stage) port
    logic              mem_ce_i;
    logic              mem_we_i;
    logic [3:0]        mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_o;

    // Stall requests toward ctrl
    logic              stallreq_if;
    logic              stallreq_mem;

    // SRAM side
    logic              sram_ce_o;
    logic              sram_we_o;
    logic [3:0]        sram_sel_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_data_o;
    logic [DATA_W-1:0] sram_data_i;

    modport slave (
        input  if_ce_i, if_addr_i,
        output if_data_o, if_ack_o,
        input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        output mem_data_o, mem_ack_o,
        output stallreq_if, stallreq_mem,
        output sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_data_o,
        input  sram_data_i
    );

    modport master (
        output if_ce_i, if_addr_i,
        input  if_data_o, if_ack_o,
        output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        input  mem_data_o, mem_ack_o,
        input  stallreq_if, stallreq_mem,
        input  sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_data_o,
        output sram_data_i
    );

endinterface

// File: rtl/sram_arbiter_pick.sv
// Combinational winner select for a fresh grant out of IDLE.
// SRAM_ARB_RR_EN defined: on a tie the port not granted most recently wins.
// Undefined: the data port always wins a tie (it is older in the pipeline).
module sram_arb_pick
    import sram_arbiter_pkg::*;
(
    input  logic     if_req,
    input  logic     mem_req,
    input  arb_gnt_e last_gnt,
    output logic     any_req,
    output arb_gnt_e gnt
);

`ifndef SRAM_ARB_RR_EN
    // Fixed priority never looks at grant history
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    // Single requester wins outright; ties resolved by the configured policy
    always_comb begin
        any_req = if_req | mem_req;
        gnt     = ARB_GNT_MEM;
        if (if_req && !mem_req) begin
            gnt = ARB_GNT_IF;
        end else if (if_req && mem_req) begin
`ifdef SRAM_ARB_RR_EN
            gnt = other_port(last_gnt);
`else
            gnt = ARB_GNT_MEM;
`endif
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch port and the
// data port. One request is latched at a time, held on the SRAM for
// ACC_CYCLES cycles, then acked for exactly one cycle (DONE). While DONE
// acks one port, a waiting request from the other port is granted directly
// so back-to-back grants cost no idle cycle.
// Build option: SRAM_ARB_RR_EN selects round-robin tie breaking.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ACC_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);

    localparam logic [ACC_CNT_W-1:0] CNT_LOAD = acc_load(ACC_CYCLES);

    arb_state_e            state_q, state_d;
    logic [ACC_CNT_W-1:0]  cnt_q, cnt_d;
    arb_gnt_e              owner_q, owner_d;
    arb_gnt_e              last_gnt_q, last_gnt_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic                  pick_any;
    arb_gnt_e              pick_gnt;
    logic                  grant_req;
    arb_gnt_e              grant_port;
    logic                  if_ack;
    logic                  mem_ack;
    logic                  in_access;

    sram_arb_pick u_pick (
        .if_req   (bus.if_ce_i),
        .mem_req  (bus.mem_ce_i),
        .last_gnt (last_gnt_q),
        .any_req  (pick_any),
        .gnt      (pick_gnt)
    );

    // State, counter and latched request; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            owner_q    <= ARB_GNT_IF;
            last_gnt_q <= ARB_GNT_IF;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next-state logic: grant from IDLE or DONE, count down the access,
    // capture read data on the last access cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        grant_req  = 1'b0;
        grant_port = pick_gnt;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_req  = 1'b1;
                    grant_port = pick_gnt;
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d = we_q ? '0 : bus.sram_data_i;
                    state_d = ARB_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_DONE: begin
                // The port being acked is ignored this cycle (turnaround)
                if (owner_q == ARB_GNT_IF && bus.mem_ce_i) begin
                    grant_req  = 1'b1;
                    grant_port = ARB_GNT_MEM;
                end else if (owner_q == ARB_GNT_MEM && bus.if_ce_i) begin
                    grant_req  = 1'b1;
                    grant_port = ARB_GNT_IF;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (grant_req) begin
            state_d    = ARB_ACCESS;
            cnt_d      = CNT_LOAD;
            owner_d    = grant_port;
            last_gnt_d = grant_port;
            if (grant_port == ARB_GNT_MEM) begin
                we_d    = bus.mem_we_i;
                sel_d   = bus.mem_sel_i;
                addr_d  = bus.mem_addr_i;
                wdata_d = bus.mem_data_i;
            end else begin
                we_d    = 1'b0;
                sel_d   = SEL_ALL;
                addr_d  = bus.if_addr_i;
                wdata_d = '0;
            end
        end
    end

    // Outputs: SRAM controls only during ACCESS, acks/data only in DONE,
    // stall requests straight from the ce inputs
    always_comb begin
        in_access = (state_q == ARB_ACCESS);
        if_ack    = (state_q == ARB_DONE) && (owner_q == ARB_GNT_IF);
        mem_ack   = (state_q == ARB_DONE) && (owner_q == ARB_GNT_MEM);

        bus.sram_ce_o    = in_access;
        bus.sram_we_o    = in_access & we_q;
        bus.sram_sel_o   = in_access ? sel_q   : '0;
        bus.sram_addr_o  = in_access ? addr_q  : '0;
        bus.sram_data_o  = in_access ? wdata_q : '0;

        bus.if_ack_o     = if_ack;
        bus.mem_ack_o    = mem_ack;
        bus.if_data_o    = if_ack  ? rdata_q : '0;
        bus.mem_data_o   = mem_ack ? rdata_q : '0;

        bus.stallreq_if  = bus.if_ce_i  & ~if_ack;
        bus.stallreq_mem = bus.mem_ce_i & ~mem_ack;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a table of single-port transactions plus
// hand-written sequences for ties, reset mid-access, stall wiring and a
// one-cycle access build. Acks are checked against a queue of expected
// {port, data} pushed when each request is driven.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .ACC_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .ACC_CYCLES(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_chk = 0;
    int n_err = 0;

    // SRAM contents as a function of address; 0x40 holds 0x2401_0005
    function automatic logic [31:0] sram_f(input logic [31:0] a);
        return a ^ 32'h2401_0045;
    endfunction

    // SRAM models: valid data only on the last cycle of a held access
    logic [3:0] run_a = 4'd0;
    logic [3:0] run_b = 4'd0;
    always @(posedge clk) begin
        run_a <= bus_a.sram_ce_o ? run_a + 4'd1 : 4'd0;
        run_b <= bus_b.sram_ce_o ? run_b + 4'd1 : 4'd0;
    end
    assign bus_a.sram_data_i = (bus_a.sram_ce_o && run_a == 4'd1) ? sram_f(bus_a.sram_addr_o) : 32'hBAD0_BAD0;
    assign bus_b.sram_data_i = (bus_b.sram_ce_o && run_b == 4'd0) ? sram_f(bus_b.sram_addr_o) : 32'hBAD0_BAD0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_mem;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    // Monitor for dut_a: stall wiring, data gating, exclusive acks, scoreboard
    always @(negedge clk) begin
        chk(bus_a.stallreq_if === (bus_a.if_ce_i & ~bus_a.if_ack_o), "stallreq_if", 32'(bus_a.stallreq_if), 32'(bus_a.if_ce_i & ~bus_a.if_ack_o));
        chk(bus_a.stallreq_mem === (bus_a.mem_ce_i & ~bus_a.mem_ack_o), "stallreq_mem", 32'(bus_a.stallreq_mem), 32'(bus_a.mem_ce_i & ~bus_a.mem_ack_o));
        if (!bus_a.if_ack_o)  chk(bus_a.if_data_o === 32'h0, "if_data_idle", bus_a.if_data_o, 32'h0);
        if (!bus_a.mem_ack_o) chk(bus_a.mem_data_o === 32'h0, "mem_data_idle", bus_a.mem_data_o, 32'h0);
        chk(!(bus_a.if_ack_o && bus_a.mem_ack_o), "both_acks", 32'(bus_a.if_ack_o & bus_a.mem_ack_o), 32'h0);
        if (bus_a.if_ack_o || bus_a.mem_ack_o) begin
            if (sb_q.size() == 0) begin
                chk(1'b0, "unexpected_ack", 32'(bus_a.mem_ack_o), 32'h0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk(bus_a.mem_ack_o == e.is_mem, "ack_port", 32'(bus_a.mem_ack_o), 32'(e.is_mem));
                chk((e.is_mem ? bus_a.mem_data_o : bus_a.if_data_o) === e.data, "ack_data",
                    e.is_mem ? bus_a.mem_data_o : bus_a.if_data_o, e.data);
            end
        end
    end

    task automatic idle_a();
        bus_a.if_ce_i    = 1'b0;
        bus_a.if_addr_i  = 32'h7777_0000;
        bus_a.mem_ce_i   = 1'b0;
        bus_a.mem_we_i   = 1'b1;
        bus_a.mem_sel_i  = 4'h5;
        bus_a.mem_addr_i = 32'hFFFF_FFF0;
        bus_a.mem_data_i = 32'hCAFE_F00D;
    endtask

    // Wait (bounded) for the given port's ack, checking SRAM controls while held
    task automatic wait_ack(input bit is_mem, input int exp_lat, input logic [31:0] e_addr,
                            input bit e_we, input logic [3:0] e_sel, input logic [31:0] e_wd);
        int cyc = 0;
        int ce_cyc = 0;
        bit got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus_a.sram_ce_o) begin
                ce_cyc++;
                chk(bus_a.sram_addr_o === e_addr, "sram_addr", bus_a.sram_addr_o, e_addr);
                chk(bus_a.sram_we_o === e_we, "sram_we", 32'(bus_a.sram_we_o), 32'(e_we));
                chk(bus_a.sram_sel_o === e_sel, "sram_sel", 32'(bus_a.sram_sel_o), 32'(e_sel));
                chk(bus_a.sram_data_o === e_wd, "sram_wdata", bus_a.sram_data_o, e_wd);
            end
            if (is_mem ? bus_a.mem_ack_o : bus_a.if_ack_o) got = 1'b1;
        end
        chk(got && cyc == exp_lat, "ack_latency", 32'(cyc), 32'(exp_lat));
        chk(ce_cyc == exp_lat - 1, "access_cycles", 32'(ce_cyc), 32'(exp_lat - 1));
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [3:0]  exp_sel;
        int          exp_lat;
    } vec_t;

    // Both ports request together; first_mem says who must win
    task automatic run_tie(input bit first_mem, input logic [31:0] ia, input logic [31:0] ma);
        sb_t e1, e2;
        bus_a.if_ce_i    = 1'b1;
        bus_a.if_addr_i  = ia;
        bus_a.mem_ce_i   = 1'b1;
        bus_a.mem_we_i   = 1'b0;
        bus_a.mem_sel_i  = 4'hF;
        bus_a.mem_addr_i = ma;
        bus_a.mem_data_i = 32'h0;
        e1.is_mem = first_mem;  e1.data = sram_f(first_mem ? ma : ia);
        e2.is_mem = !first_mem; e2.data = sram_f(first_mem ? ia : ma);
        sb_q.push_back(e1);
        sb_q.push_back(e2);
        wait_ack(first_mem, 3, first_mem ? ma : ia, 1'b0, 4'hF, 32'h0);
        if (first_mem) bus_a.mem_ce_i = 1'b0; else bus_a.if_ce_i = 1'b0;
        wait_ack(!first_mem, 3, first_mem ? ia : ma, 1'b0, 4'hF, 32'h0);
        idle_a();
        @(negedge clk);
    endtask

    vec_t vecs[6];
    bit   tie2_mem;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0,          32'h2401_0005, 4'hF, 3};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF,  32'h0,         4'h3, 3};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0080, 32'h1111_2222,  32'h2401_00C5, 4'hF, 3};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_1000, 32'h0,          32'h2401_1045, 4'hF, 3};
        vecs[4] = '{1'b1, 1'b1, 4'h8, 32'h0000_03FC, 32'h1234_5678,  32'h0,         4'h8, 3};
        vecs[5] = '{1'b1, 1'b0, 4'h4, 32'h0000_0200, 32'h0,          32'h2401_0245, 4'h4, 3};
`ifdef SRAM_ARB_RR_EN
        tie2_mem = 1'b0;
`else
        tie2_mem = 1'b1;
`endif

        rst = 1'b0;
        idle_a();
        bus_a.if_ce_i    = 1'b1;
        bus_b.if_ce_i    = 1'b0;
        bus_b.if_addr_i  = 32'h0;
        bus_b.mem_ce_i   = 1'b0;
        bus_b.mem_we_i   = 1'b0;
        bus_b.mem_sel_i  = 4'h0;
        bus_b.mem_addr_i = 32'h0;
        bus_b.mem_data_i = 32'h0;
        repeat (3) @(negedge clk);
        chk(bus_a.sram_ce_o === 1'b0, "rst_sram_ce", 32'(bus_a.sram_ce_o), 32'h0);
        chk(bus_a.sram_addr_o === 32'h0, "rst_sram_addr", bus_a.sram_addr_o, 32'h0);
        chk(bus_a.sram_sel_o === 4'h0, "rst_sram_sel", 32'(bus_a.sram_sel_o), 32'h0);
        chk(bus_a.if_ack_o === 1'b0, "rst_if_ack", 32'(bus_a.if_ack_o), 32'h0);
        chk(bus_a.mem_ack_o === 1'b0, "rst_mem_ack", 32'(bus_a.mem_ack_o), 32'h0);
        bus_a.if_ce_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // First tie after reset goes to the data port in either policy
        run_tie(1'b1, 32'h0000_0500, 32'h0000_0600);

        for (int i = 0; i < 6; i++) begin
            sb_t e;
            idle_a();
            if (vecs[i].is_mem) begin
                bus_a.mem_ce_i   = 1'b1;
                bus_a.mem_we_i   = vecs[i].we;
                bus_a.mem_sel_i  = vecs[i].sel;
                bus_a.mem_addr_i = vecs[i].addr;
                bus_a.mem_data_i = vecs[i].wdata;
            end else begin
                bus_a.if_ce_i    = 1'b1;
                bus_a.if_addr_i  = vecs[i].addr;
            end
            e.is_mem = vecs[i].is_mem;
            e.data   = vecs[i].exp_data;
            sb_q.push_back(e);
            wait_ack(vecs[i].is_mem, vecs[i].exp_lat, vecs[i].addr, vecs[i].we,
                     vecs[i].exp_sel, vecs[i].is_mem ? vecs[i].wdata : 32'h0);
            idle_a();
            @(negedge clk);
            chk(bus_a.sram_ce_o === 1'b0, "post_txn_idle", 32'(bus_a.sram_ce_o), 32'h0);
        end

        // Last grant was the data port: round-robin hands this tie to fetch
        run_tie(tie2_mem, 32'h0000_0700, 32'h0000_0800);

        // Reset during the second access cycle abandons the access
        bus_a.if_ce_i   = 1'b1;
        bus_a.if_addr_i = 32'h0000_0080;
        @(negedge clk);
        chk(bus_a.sram_ce_o === 1'b1, "rst_mid_acc1", 32'(bus_a.sram_ce_o), 32'h1);
        @(negedge clk);
        chk(bus_a.sram_ce_o === 1'b1, "rst_mid_acc2", 32'(bus_a.sram_ce_o), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk(bus_a.sram_ce_o === 1'b0, "rst_mid_ce", 32'(bus_a.sram_ce_o), 32'h0);
        chk(bus_a.if_ack_o === 1'b0, "rst_mid_noack", 32'(bus_a.if_ack_o), 32'h0);
        rst = 1'b1;
        begin
            sb_t e;
            e.is_mem = 1'b0;
            e.data   = sram_f(32'h0000_0080);
            sb_q.push_back(e);
        end
        wait_ack(1'b0, 3, 32'h0000_0080, 1'b0, 4'hF, 32'h0);
        idle_a();
        @(negedge clk);

        // Both ce held 10 cycles: alternating grants, stall lines watched by the monitor
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus_a.if_ce_i    = 1'b1;
        bus_a.if_addr_i  = 32'h0000_0044;
        bus_a.mem_ce_i   = 1'b1;
        bus_a.mem_we_i   = 1'b0;
        bus_a.mem_sel_i  = 4'hF;
        bus_a.mem_addr_i = 32'h0000_0088;
        bus_a.mem_data_i = 32'h0;
        for (int k = 0; k < 4; k++) begin
            sb_t e;
            e.is_mem = (k % 2 == 0);
            e.data   = sram_f(e.is_mem ? 32'h0000_0088 : 32'h0000_0044);
            sb_q.push_back(e);
        end
        repeat (10) @(negedge clk);
        idle_a();
        repeat (4) @(negedge clk);
        chk(sb_q.size() == 0, "stall_seq_drained", 32'(sb_q.size()), 32'h0);

        // One-cycle access build: data read at 0x200, ce held through DONE
        bus_b.mem_ce_i   = 1'b1;
        bus_b.mem_we_i   = 1'b0;
        bus_b.mem_sel_i  = 4'hF;
        bus_b.mem_addr_i = 32'h0000_0200;
        @(negedge clk);
        chk(bus_b.sram_ce_o === 1'b1, "b_access", 32'(bus_b.sram_ce_o), 32'h1);
        chk(bus_b.sram_addr_o === 32'h0000_0200, "b_sram_addr", bus_b.sram_addr_o, 32'h0000_0200);
        chk(bus_b.mem_ack_o === 1'b0, "b_no_early_ack", 32'(bus_b.mem_ack_o), 32'h0);
        @(negedge clk);
        chk(bus_b.mem_ack_o === 1'b1, "b_ack", 32'(bus_b.mem_ack_o), 32'h1);
        chk(bus_b.mem_data_o === 32'h2401_0245, "b_data", bus_b.mem_data_o, 32'h2401_0245);
        chk(bus_b.sram_ce_o === 1'b0, "b_done_ce", 32'(bus_b.sram_ce_o), 32'h0);
        chk(bus_b.stallreq_mem === 1'b0, "b_stall_done", 32'(bus_b.stallreq_mem), 32'h0);
        @(negedge clk);
        chk(bus_b.sram_ce_o === 1'b0, "b_no_regrant", 32'(bus_b.sram_ce_o), 32'h0);
        chk(bus_b.mem_ack_o === 1'b0, "b_ack_one_cycle", 32'(bus_b.mem_ack_o), 32'h0);
        bus_b.mem_ce_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
